// File: rtl/maze_rom_arbiter_pkg.sv
// Shared maze map geometry, port identifiers and the response tag carried
// alongside each accepted ROM read.
package maze_pkg;

    localparam int MAP_WIDTH = 30;
    localparam int MAP_DEPTH = 21;
    localparam int ROW_W     = 5;

    localparam logic PORT_RD = 1'b0;
    localparam logic PORT_MV = 1'b1;

    typedef struct packed {
        logic vld;
        logic port;
        logic oob;
    } tag_t;

endpackage

// File: rtl/maze_arb_tagpipe.sv
// Two-stage tag delay line matching the ROM read latency, so each response
// knows which port it belongs to and whether it must be forced to a wall row.
module maze_arb_tagpipe
    import maze_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  tag_t tag,
    output tag_t tag_p1
);

    logic vld_p0, vld_p1;
    logic port_p0, port_p1;
    logic oob_p0, oob_p1;

    // Only the valid bits need clearing; port/oob are ignored while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= tag.vld;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        port_p0 <= tag.port;
        oob_p0  <= tag.oob;
        port_p1 <= port_p0;
        oob_p1  <= oob_p0;
    end

    assign tag_p1.vld  = vld_p1;
    assign tag_p1.port = port_p1;
    assign tag_p1.oob  = oob_p1;

endmodule

// File: rtl/maze_rom_arbiter.sv
// Arbitrates a render port and a move/collision port onto one single-port map
// ROM, with starvation protection for the move port and in-order responses.
module maze_rom_arbiter #(
    parameter int MAP_WIDTH  = maze_pkg::MAP_WIDTH,
    parameter int MAP_DEPTH  = maze_pkg::MAP_DEPTH,
    parameter int ROW_W      = maze_pkg::ROW_W,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [ROW_W-1:0]     rd_row,
    output logic                 rd_ack,
    output logic                 rd_valid,
    output logic [MAP_WIDTH-1:0] rd_data,
    input  logic                 mv_req,
    input  logic [ROW_W-1:0]     mv_row,
    output logic                 mv_ack,
    output logic                 mv_valid,
    output logic [MAP_WIDTH-1:0] mv_data,
    output logic                 mv_oob,
    output logic [ROW_W-1:0]     rom_addr,
    input  logic [MAP_WIDTH-1:0] rom_data
);

    import maze_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(STARVE_MAX)) ? cnt : cnt + CNT_W'(1);
    endfunction

    function automatic logic row_oob(input logic [ROW_W-1:0] row);
        return 32'(row) >= MAP_DEPTH;
    endfunction

    function automatic logic [MAP_WIDTH-1:0] wall_fill(input logic oob,
                                                       input logic [MAP_WIDTH-1:0] data);
        return oob ? '1 : data;
    endfunction

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             accept;
    logic [ROW_W-1:0] sel_row;
    tag_t             tag;
    tag_t             tag_p1;
    logic [MAP_WIDTH-1:0] resp_p2;

    // Move wins only once it has been denied STARVE_MAX cycles in a row.
    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
    assign mv_ack  = !reset && mv_req && (!rd_req || starved);
    assign rd_ack  = !reset && rd_req && !mv_ack;
    assign accept  = rd_ack || mv_ack;
    assign sel_row = mv_ack ? mv_row : rd_row;

    assign tag.vld  = accept;
    assign tag.port = mv_ack ? PORT_MV : PORT_RD;
    assign tag.oob  = row_oob(sel_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!mv_req || mv_ack) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Stage 0: address register to the ROM
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
        end else if (accept) begin
            rom_addr <= sel_row;
        end
    end

    maze_arb_tagpipe u_tagpipe (
        .clk    (clk),
        .reset  (reset),
        .tag    (tag),
        .tag_p1 (tag_p1)
    );

    // Stage 2: steer ROM data (or a wall row) to the owning port
    assign resp_p2 = wall_fill(tag_p1.oob, rom_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            mv_valid <= 1'b0;
            mv_oob   <= 1'b0;
            rd_data  <= '0;
            mv_data  <= '0;
        end else begin
            rd_valid <= tag_p1.vld && (tag_p1.port == PORT_RD);
            mv_valid <= tag_p1.vld && (tag_p1.port == PORT_MV);
            if (tag_p1.vld && (tag_p1.port == PORT_RD)) begin
                rd_data <= resp_p2;
            end
            if (tag_p1.vld && (tag_p1.port == PORT_MV)) begin
                mv_data <= resp_p2;
                mv_oob  <= tag_p1.oob;
            end
        end
    end

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Bench for maze_rom_arbiter: table-driven request vectors with expected acks,
// and a per-port response scoreboard checked against a behavioural ROM.
module tb_maze_rom_arbiter;

    localparam int MW    = 30;
    localparam int RW    = 5;
    localparam int DEPTH = 21;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req, mv_req;
    logic [RW-1:0] rd_row, mv_row;
    logic          rd_ack, mv_ack, rd_valid, mv_valid, mv_oob;
    logic [MW-1:0] rd_data, mv_data, rom_data;
    logic [RW-1:0] rom_addr;

    always #5 clk = ~clk;

    maze_rom_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mv_req   (mv_req),
        .mv_row   (mv_row),
        .mv_ack   (mv_ack),
        .mv_valid (mv_valid),
        .mv_data  (mv_data),
        .mv_oob   (mv_oob),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    function automatic logic [MW-1:0] map_row(input logic [RW-1:0] r);
        logic [31:0] h;
        h = (32'(r) + 32'd1) * 32'h9E3779B1;
        return h[31:2];
    endfunction

    // Synchronous map ROM: data for rom_addr appears one clock later.
    always @(posedge clk) rom_data <= map_row(rom_addr);

    typedef struct {
        logic          rst;
        logic          rr;
        logic [RW-1:0] rrow;
        logic          mr;
        logic [RW-1:0] mrow;
        logic          er;
        logic          em;
    } vec_t;

    typedef struct {
        int            due;
        logic [MW-1:0] data;
        logic          oob;
    } resp_t;

    vec_t  vecs[$];
    resp_t rd_q[$];
    resp_t mv_q[$];

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    bit            armed = 1'b0;
    logic [MW-1:0] last_rd = '0;
    logic [MW-1:0] last_mv = '0;
    logic          last_oob = 1'b0;
    logic [RW-1:0] exp_addr = '0;

    function automatic vec_t mk(input logic rst, input logic rr, input int rrow,
                                input logic mr, input int mrow,
                                input logic er, input logic em);
        vec_t v;
        v.rst = rst; v.rr = rr; v.rrow = RW'(rrow);
        v.mr = mr; v.mrow = RW'(mrow); v.er = er; v.em = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        resp_t r;
        logic  exp_v;
        reset  = v.rst;
        rd_req = v.rr;
        rd_row = v.rrow;
        mv_req = v.mr;
        mv_row = v.mrow;
        @(negedge clk);
        if (armed) begin
            exp_v = (rd_q.size() != 0) && (rd_q[0].due == cyc);
            chk("rd_valid", 32'(rd_valid), 32'(exp_v));
            if (exp_v) begin
                r = rd_q.pop_front();
                last_rd = r.data;
            end
            chk("rd_data", 32'(rd_data), 32'(last_rd));
            exp_v = (mv_q.size() != 0) && (mv_q[0].due == cyc);
            chk("mv_valid", 32'(mv_valid), 32'(exp_v));
            if (exp_v) begin
                r = mv_q.pop_front();
                last_mv  = r.data;
                last_oob = r.oob;
            end
            chk("mv_data", 32'(mv_data), 32'(last_mv));
            chk("mv_oob", 32'(mv_oob), 32'(last_oob));
            chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
            chk("rd_ack", 32'(rd_ack), 32'(v.er));
            chk("mv_ack", 32'(mv_ack), 32'(v.em));
        end
        if (v.er) begin
            r.due  = cyc + 3;
            r.data = (32'(v.rrow) >= DEPTH) ? '1 : map_row(v.rrow);
            r.oob  = 1'b0;
            rd_q.push_back(r);
            exp_addr = v.rrow;
        end
        if (v.em) begin
            r.due  = cyc + 3;
            r.oob  = (32'(v.mrow) >= DEPTH);
            r.data = r.oob ? '1 : map_row(v.mrow);
            mv_q.push_back(r);
            exp_addr = v.mrow;
        end
        if (v.rst) begin
            rd_q.delete();
            mv_q.delete();
            last_rd  = '0;
            last_mv  = '0;
            last_oob = 1'b0;
            exp_addr = '0;
            armed    = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b1; rd_req = 1'b0; mv_req = 1'b0; rd_row = '0; mv_row = '0;

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // single render read of row 3
        vecs.push_back(mk(0, 1, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // both held: three render grants, then the starved move port
        vecs.push_back(mk(0, 1, 4, 1, 9, 1, 0));
        vecs.push_back(mk(0, 1, 5, 1, 9, 1, 0));
        vecs.push_back(mk(0, 1, 6, 1, 9, 1, 0));
        vecs.push_back(mk(0, 1, 7, 1, 9, 0, 1));
        // counter restarted by the move grant
        vecs.push_back(mk(0, 1, 7, 1, 10, 1, 0));
        vecs.push_back(mk(0, 1, 8, 1, 10, 1, 0));
        vecs.push_back(mk(0, 1, 9, 1, 10, 1, 0));
        vecs.push_back(mk(0, 1, 10, 1, 10, 0, 1));
        vecs.push_back(mk(0, 1, 10, 0, 0, 1, 0));
        // counter cleared when mv_req drops
        vecs.push_back(mk(0, 1, 11, 1, 12, 1, 0));
        vecs.push_back(mk(0, 1, 12, 1, 12, 1, 0));
        vecs.push_back(mk(0, 1, 13, 0, 12, 1, 0));
        vecs.push_back(mk(0, 1, 14, 1, 12, 1, 0));
        vecs.push_back(mk(0, 1, 15, 1, 12, 1, 0));
        vecs.push_back(mk(0, 1, 16, 1, 12, 1, 0));
        vecs.push_back(mk(0, 1, 17, 1, 12, 0, 1));
        vecs.push_back(mk(0, 1, 17, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // out-of-range and boundary rows
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 25, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 20, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 21, 0, 1));
        vecs.push_back(mk(0, 1, 31, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 20, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // alternating single requests with idle gaps
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // render streams every row back to back
        for (int r = 0; r < DEPTH; r++) apply(mk(0, 1, r, 0, 0, 1, 0));
        idle(4);

        // reset lands while a move and a render read are in flight
        apply(mk(0, 0, 0, 1, 3, 0, 1));
        apply(mk(0, 1, 8, 0, 0, 1, 0));
        apply(mk(1, 1, 9, 1, 4, 0, 0));
        apply(mk(0, 1, 4, 0, 0, 1, 0));
        idle(5);

        // reset while the move port is partly starved, then starve again
        apply(mk(0, 1, 1, 1, 2, 1, 0));
        apply(mk(0, 1, 2, 1, 2, 1, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 3, 1, 2, 1, 0));
        apply(mk(0, 1, 4, 1, 2, 1, 0));
        apply(mk(0, 1, 5, 1, 2, 1, 0));
        apply(mk(0, 1, 6, 1, 2, 0, 1));
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
